// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between a display reader and a CPU
//
// Purpose:
//   Grants one VRAM access per Clk cycle. Priority: display read, CPU write,
//   CPU read. Display reads are never delayed and return data two cycles after
//   they are sampled. A CPU read returns data two cycles after its ack. An
//   8-bit saturating wait counter drives cpu_starve.
//
// Optional build macro:
//   VRAM_ARB_WFIFO_EN - adds a WFIFO_DEPTH-entry CPU write FIFO. Writes are
//   acked on enqueue, even alongside a display read. The FIFO head drains in
//   any cycle without disp_req. CPU reads wait until the FIFO is empty.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   disp_req/disp_addr  display read request (one cycle) and address
//   disp_data/disp_valid display read data and its valid pulse
//   cpu_req/cpu_we      CPU request (held until ack), 1 = write
//   cpu_addr/cpu_wdata  CPU address and write data
//   cpu_ack             one-cycle pulse when the CPU request is accepted
//   cpu_rdata/cpu_rvalid CPU read data and its valid pulse
//   cpu_starve          wait counter >= STARVE_MAX
//   ram_addr/ram_we/ram_wdata registered VRAM controls
//   ram_rdata           VRAM read data, one-cycle synchronous read
module vram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int STARVE_MAX  = 16,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_starve,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    if (WFIFO_DEPTH < 2 || (WFIFO_DEPTH & (WFIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("WFIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISP_RD = 2'd1,
        CPU_RD  = 2'd2,
        CPU_WR  = 2'd3
    } state_t;

    // state records the access issued this cycle, so it doubles as the
    // first stage of the read-return pipeline.
    state_t            state;
    state_t            state_nxt;
    logic              cpu_grant;
    logic              disp_p2;
    logic              cpu_p2;
    logic              rd_busy;
    logic [7:0]        wait_cnt;
    logic [7:0]        wait_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Only one CPU read may be in flight.
    assign rd_busy = (state == CPU_RD) || cpu_p2;

`ifdef VRAM_ARB_WFIFO_EN
    localparam int PTR_W = $clog2(WFIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              enq;
    logic              deq;

    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(WFIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign wr_addr    = fifo_addr[rd_ptr];
    assign wr_data    = fifo_data[rd_ptr];

    always_comb begin
        state_nxt = IDLE;
        cpu_grant = 1'b0;
        enq       = 1'b0;
        deq       = 1'b0;
        if (disp_req) begin
            state_nxt = DISP_RD;
        end
        // Enqueue does not use the VRAM slot, so it proceeds alongside display.
        if (cpu_req && cpu_we && !fifo_full) begin
            cpu_grant = 1'b1;
            enq       = 1'b1;
        end
        if (!disp_req) begin
            if (!fifo_empty) begin
                state_nxt = CPU_WR;
                deq       = 1'b1;
            end else if (cpu_req && !cpu_we && !rd_busy) begin
                state_nxt = CPU_RD;
                cpu_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge Clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= cpu_addr;
            fifo_data[wr_ptr] <= cpu_wdata;
        end
    end
`else
    assign wr_addr = cpu_addr;
    assign wr_data = cpu_wdata;

    always_comb begin
        state_nxt = IDLE;
        cpu_grant = 1'b0;
        if (disp_req) begin
            state_nxt = DISP_RD;
        end else if (cpu_req) begin
            if (cpu_we) begin
                state_nxt = CPU_WR;
                cpu_grant = 1'b1;
            end else if (!rd_busy) begin
                state_nxt = CPU_RD;
                cpu_grant = 1'b1;
            end
        end
    end
`endif

    // A dropped request clears the counter just like a grant does.
    always_comb begin
        if (cpu_grant || !cpu_req) begin
            wait_nxt = '0;
        end else if (wait_cnt != 8'hFF) begin
            wait_nxt = wait_cnt + 8'd1;
        end else begin
            wait_nxt = wait_cnt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            disp_p2    <= 1'b0;
            cpu_p2     <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cpu_ack    <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            wait_cnt   <= '0;
            cpu_starve <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_ack    <= cpu_grant;
            wait_cnt   <= wait_nxt;
            cpu_starve <= (int'(wait_nxt) >= STARVE_MAX);
            ram_we     <= (state_nxt == CPU_WR);
            case (state_nxt)
                DISP_RD: ram_addr <= disp_addr;
                CPU_RD:  ram_addr <= cpu_addr;
                CPU_WR: begin
                    ram_addr  <= wr_addr;
                    ram_wdata <= wr_data;
                end
                default: ram_addr <= ram_addr;
            endcase
            // RAM samples ram_addr one edge after issue; data is captured the edge after.
            disp_p2    <= (state == DISP_RD);
            cpu_p2     <= (state == CPU_RD);
            disp_valid <= disp_p2;
            cpu_rvalid <= cpu_p2;
            if (disp_p2) begin
                disp_data <= ram_rdata;
            end
            if (cpu_p2) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int STARVE_MAX  = 16;
    localparam int WFIFO_DEPTH = 4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_starve;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0]        mem [256];
    logic [ADDR_W+DATA_W-1:0] wlog [$];
    int checks = 0;
    int errors = 0;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .WFIFO_DEPTH(WFIFO_DEPTH)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_starve(cpu_starve),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #10 Clk = ~Clk;

    // VRAM model: 256 words, initial content = low address byte ^ 0x79 (0x23 -> 0x5A).
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h79;
        end else begin
            ram_rdata <= mem[ram_addr[7:0]];
            if (ram_we) begin
                mem[ram_addr[7:0]] <= ram_wdata;
                wlog.push_back({ram_addr, ram_wdata});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        disp_req = 0; cpu_req = 0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({ram_addr, ram_we, ram_wdata, disp_valid, disp_data, cpu_ack, cpu_rvalid, cpu_rdata, cpu_starve} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {ram_addr, ram_we, ram_wdata, disp_valid, disp_data, cpu_ack, cpu_rvalid, cpu_rdata, cpu_starve});
        end
        Reset = 0;
        tick();
    endtask

    task automatic test_disp_read();
        disp_req = 1; disp_addr = 16'h0123;
        tick();
        disp_req = 0; disp_addr = 16'h0000;
        checks++;
        if (ram_addr !== 16'h0123 || ram_we !== 1'b0) begin
            errors++; $display("FAIL disp_issue: ram_addr=%h ram_we=%b required 0123/0", ram_addr, ram_we);
        end
        tick();
        checks++;
        if (disp_valid !== 1'b0) begin
            errors++; $display("FAIL disp_early: disp_valid=%b required 0", disp_valid);
        end
        tick();
        checks++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h5A) begin
            errors++; $display("FAIL disp_return: valid=%b data=%h required 1/5a", disp_valid, disp_data);
        end
        tick();
        checks++;
        if (disp_valid !== 1'b0) begin
            errors++; $display("FAIL disp_pulse: disp_valid=%b required 0", disp_valid);
        end
        idle(2);
    endtask

    task automatic test_disp_cpu_write();
        wlog.delete();
        disp_req = 1; disp_addr = 16'h0200;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 8'hA5;
        tick();
`ifdef VRAM_ARB_WFIFO_EN
        checks++;
        if (cpu_ack !== 1'b1 || ram_we !== 1'b0) begin
            errors++; $display("FAIL wr_collide_e20: ack=%b we=%b required 1/0", cpu_ack, ram_we);
        end
        cpu_req = 0; disp_req = 0;
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 16'h0040 || ram_wdata !== 8'hA5) begin
            errors++; $display("FAIL wr_collide_e21: ack=%b we=%b addr=%h data=%h required 0/1/0040/a5",
                               cpu_ack, ram_we, ram_addr, ram_wdata);
        end
`else
        checks++;
        if (cpu_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 16'h0200) begin
            errors++; $display("FAIL wr_collide_e20: ack=%b we=%b addr=%h required 0/0/0200", cpu_ack, ram_we, ram_addr);
        end
        disp_req = 0;
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'h0040 || ram_wdata !== 8'hA5) begin
            errors++; $display("FAIL wr_collide_e21: ack=%b we=%b addr=%h data=%h required 1/1/0040/a5",
                               cpu_ack, ram_we, ram_addr, ram_wdata);
        end
        cpu_req = 0;
`endif
        tick();
        checks++;
        if (ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++; $display("FAIL wr_one_cycle: we=%b ack=%b required 0/0", ram_we, cpu_ack);
        end
        idle(3);
        checks++;
        if (wlog.size() !== 1 || wlog[0] !== {16'h0040, 8'hA5}) begin
            errors++; $display("FAIL wr_collide_log: entries=%0d first=%h required 1/0040a5", wlog.size(),
                               (wlog.size() > 0) ? wlog[0] : 24'h0);
        end
    endtask

    task automatic test_starve();
        logic ack_seen;
        ack_seen = 0;
        disp_req = 1; disp_addr = 16'h0300;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0123;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_ack !== 1'b0) ack_seen = 1;
            if (i == 15) begin
                checks++;
                if (cpu_starve !== 1'b0) begin
                    errors++; $display("FAIL starve_15: cpu_starve=%b required 0", cpu_starve);
                end
            end
            if (i == 16 || i == 20) begin
                checks++;
                if (cpu_starve !== 1'b1) begin
                    errors++; $display("FAIL starve_%0d: cpu_starve=%b required 1", i, cpu_starve);
                end
            end
        end
        checks++;
        if (ack_seen !== 1'b0) begin
            errors++; $display("FAIL starve_no_ack: ack seen=%b required 0", ack_seen);
        end
        disp_req = 0;
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_starve !== 1'b0) begin
            errors++; $display("FAIL starve_release: ack=%b starve=%b required 1/0", cpu_ack, cpu_starve);
        end
        cpu_req = 0;
        tick();
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) begin
            errors++; $display("FAIL cpu_read_return: rvalid=%b rdata=%h required 1/5a", cpu_rvalid, cpu_rdata);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++; $display("FAIL cpu_rvalid_pulse: rvalid=%b required 0", cpu_rvalid);
        end
        idle(2);
    endtask

    task automatic test_req_drop();
        logic ack_seen;
        ack_seen = 0;
        disp_req = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0005;
        repeat (10) begin tick(); if (cpu_ack !== 1'b0) ack_seen = 1; end
        cpu_req = 0;
        tick();
        if (cpu_ack !== 1'b0) ack_seen = 1;
        cpu_req = 1;
        repeat (10) begin tick(); if (cpu_ack !== 1'b0) ack_seen = 1; end
        checks++;
        if (cpu_starve !== 1'b0) begin
            errors++; $display("FAIL drop_clears_wait: cpu_starve=%b required 0", cpu_starve);
        end
        cpu_req = 0; disp_req = 0;
        repeat (3) begin tick(); if (cpu_ack !== 1'b0 || cpu_rvalid !== 1'b0) ack_seen = 1; end
        checks++;
        if (ack_seen !== 1'b0) begin
            errors++; $display("FAIL drop_no_ack: ack/rvalid seen=%b required 0", ack_seen);
        end
    endtask

    task automatic test_saturate();
        logic bad;
        bad = 0;
        disp_req = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0006;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (cpu_ack !== 1'b0 || cpu_starve !== (i >= STARVE_MAX)) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL starve_saturate: deviation seen=%b required 0", bad);
        end
        disp_req = 0;
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_starve !== 1'b0) begin
            errors++; $display("FAIL saturate_release: ack=%b starve=%b required 1/0", cpu_ack, cpu_starve);
        end
        idle(4);
    endtask

    task automatic test_back_to_back();
        int k;
        logic exp_ack;
        wlog.delete();
        k = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_wdata = 8'h10;
`ifdef VRAM_ARB_WFIFO_EN
        disp_req = 1; disp_addr = 16'h0400;
        for (int t = 1; t <= 8; t++) begin
            if (t == 7) disp_req = 0;
            tick();
            exp_ack = (t <= 4) || (t == 8);
            checks++;
            if (cpu_ack !== exp_ack) begin
                errors++; $display("FAIL b2b_ack_%0d: ack=%b required %b", t, cpu_ack, exp_ack);
            end
            if (cpu_ack === 1'b1) begin
                k++;
                if (k < 5) begin cpu_addr = 16'h0100 + 16'(k); cpu_wdata = 8'h10 + 8'(k); end
                else cpu_req = 0;
            end
        end
`else
        disp_req = 0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            exp_ack = 1'b1;
            checks++;
            if (cpu_ack !== exp_ack || ram_we !== 1'b1 || ram_addr !== 16'h0100 + 16'(t - 1)) begin
                errors++; $display("FAIL b2b_write_%0d: ack=%b we=%b addr=%h required 1/1/%h",
                                   t, cpu_ack, ram_we, ram_addr, 16'h0100 + 16'(t - 1));
            end
            if (cpu_ack === 1'b1) begin
                k++;
                if (k < 5) begin cpu_addr = 16'h0100 + 16'(k); cpu_wdata = 8'h10 + 8'(k); end
                else cpu_req = 0;
            end
        end
`endif
        idle(6);
        checks++;
        if (wlog.size() !== 5) begin
            errors++; $display("FAIL b2b_count: writes=%0d required 5", wlog.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (wlog[j] !== {16'h0100 + 16'(j), 8'h10 + 8'(j)}) begin
                    errors++; $display("FAIL b2b_order_%0d: got %h required %h", j, wlog[j],
                                       {16'h0100 + 16'(j), 8'h10 + 8'(j)});
                end
            end
        end
    endtask

    task automatic test_read_after_write();
        disp_req = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 8'h33;
        tick();
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++; $display("FAIL raw_write_ack: ack=%b required 1", cpu_ack);
        end
        cpu_we = 0;
        tick();
`ifdef VRAM_ARB_WFIFO_EN
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++; $display("FAIL raw_read_stall: ack=%b required 0", cpu_ack);
        end
        tick();
`endif
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++; $display("FAIL raw_read_ack: ack=%b required 1", cpu_ack);
        end
        cpu_req = 0;
        tick();
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h33) begin
            errors++; $display("FAIL raw_read_data: rvalid=%b rdata=%h required 1/33", cpu_rvalid, cpu_rdata);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        seen = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0123;
        tick();
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++; $display("FAIL rst_read_ack: ack=%b required 1", cpu_ack);
        end
        cpu_req = 0;
        tick();
        Reset = 1;
        #1;
        checks++;
        if ({ram_addr, ram_we, ram_wdata, disp_valid, disp_data, cpu_ack, cpu_rvalid, cpu_rdata, cpu_starve} !== '0) begin
            errors++;
            $display("FAIL rst_async_outputs: got %h required 0",
                     {ram_addr, ram_we, ram_wdata, disp_valid, disp_data, cpu_ack, cpu_rvalid, cpu_rdata, cpu_starve});
        end
        tick();
        if (cpu_rvalid !== 1'b0) seen = 1;
        Reset = 0;
        repeat (4) begin tick(); if (cpu_rvalid !== 1'b0 || disp_valid !== 1'b0) seen = 1; end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_drops_read: valid pulse seen=%b required 0", seen);
        end
    endtask

    initial begin
        disp_req = 0; disp_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        test_reset();
        test_disp_read();
        test_disp_cpu_write();
        test_starve();
        test_req_drop();
        test_saturate();
        test_back_to_back();
        test_read_after_write();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, VRAM address width; DATA_W, default 8, VRAM data width; STARVE_MAX, default 16, CPU wait cycles before starve flag; WFIFO_DEPTH, default 4, write FIFO entries (power of 2).
REQ-002 SHALL have ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  reset, asynchronous, active-high.
- disp_req  in  1  display read request, one cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_data  out  DATA_W  display read data.
- disp_valid  out  1  disp_data valid pulse.
- cpu_req  in  1  CPU access request, held until acked.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  request accepted, one-cycle pulse.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid pulse.
- cpu_starve  out  1  CPU waited at least STARVE_MAX cycles.
- ram_addr  out  ADDR_W  VRAM address, registered.
- ram_we  out  1  VRAM write enable, registered.
- ram_wdata  out  DATA_W  VRAM write data, registered.
- ram_rdata  in  DATA_W  VRAM read data, one-cycle synchronous read.

Function
REQ-003 SHALL arbitrate one VRAM access per Clk cycle, in this priority order: display read, CPU write (FIFO head when enabled), CPU read.
REQ-004 SHALL use a state register with states IDLE, DISP_RD, CPU_RD and CPU_WR, updated every edge to the access granted that cycle, or IDLE if there is no grant.
REQ-005 SHALL, for disp_req sampled high at edge E, drive ram_addr=disp_addr and ram_we=0 from E, and pulse disp_valid with disp_data=ram_rdata at E+2 (fixed 2-cycle latency).
REQ-006 SHALL always grant disp_req in the cycle it is sampled; display access is never delayed.
REQ-007 SHALL assert cpu_ack for exactly one cycle at the edge a CPU request is granted; the requester holds cpu_req, cpu_we, cpu_addr and cpu_wdata stable until then.
REQ-008 SHALL, for a granted CPU read at edge E, pulse cpu_rvalid with cpu_rdata at E+2; only one CPU read is outstanding.
REQ-009 SHALL, for a granted CPU write, drive ram_we=1 with ram_addr and ram_wdata for exactly one cycle.
REQ-010 SHALL, when disp_req and cpu_req are high together, grant display and hold the CPU with cpu_ack=0.
REQ-011 SHALL run an 8-bit saturating wait counter that increments each cycle cpu_req=1 and cpu_ack=0, clears on cpu_ack, and stops at 255 without wrapping.
REQ-012 SHALL set cpu_starve=1 while the wait counter is at least STARVE_MAX.
REQ-013 SHALL not acknowledge a cpu_req that falls before being granted; the wait counter clears on that cycle.

Reset
REQ-014 SHALL, on Reset, asynchronously force state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, disp_valid=0, disp_data=0, cpu_ack=0, cpu_rvalid=0, cpu_rdata=0, cpu_starve=0, wait counter=0, FIFO empty.
REQ-015 SHALL drop reads in flight when Reset is asserted mid-operation; no disp_valid or cpu_rvalid pulse follows reset release for them.

Configuration
REQ-016 SHALL compile a write FIFO of WFIFO_DEPTH entries when macro VRAM_ARB_WFIFO_EN is defined.
REQ-017 SHALL, with VRAM_ARB_WFIFO_EN defined:
- acknowledge a CPU write on the edge it is enqueued, when the FIFO is not full, even if disp_req=1;
- hold cpu_ack=0 while the FIFO is full;
- drain the FIFO head in any cycle without disp_req, in FIFO order;
- stall CPU reads (no ack) until the FIFO is empty, preserving read-after-write order;
- clear the wait counter on enqueue.
REQ-018 SHALL, without VRAM_ARB_WFIFO_EN, contain no FIFO storage and acknowledge CPU writes only when the VRAM write slot is granted.

Verification
REQ-019 SHALL cover: disp_req at edge 10, addr 0x0123, RAM holds 0x5A -> ram_addr=0x0123 from edge 10, disp_valid with 0x5A at edge 12.
REQ-020 SHALL cover: disp_req and CPU write 0x0040 <- 0xA5 at edge 20, disp_req low at 21 -> FIFO off: cpu_ack at 21, ram_we one cycle; FIFO on: cpu_ack at 20, ram_we at 21.
REQ-021 SHALL cover: disp_req held high 20 cycles with cpu_req pending, STARVE_MAX=16 -> cpu_starve rises after 16 wait cycles; cpu_ack and counter clear on the first free cycle.
REQ-022 SHALL cover: FIFO on, 5 back-to-back CPU writes under continuous disp_req -> 4 acks, then cpu_ack=0 until first drain; VRAM receives all 5 in order.
REQ-023 SHALL cover: FIFO on, write 0x0010 <- 0x33 then read 0x0010 -> read acked only after FIFO empty, cpu_rdata=0x33.
REQ-024 SHALL cover: Reset pulsed one cycle after a CPU read ack -> no cpu_rvalid; all outputs at REQ-014 values.
